// File: rtl/fpdiv_result_stage.sv
// fpdiv_result_stage
//
// Completion stage behind the pipelined Newton-Raphson FP32 divider. A tag
// pipe follows every issued operation through the divider's fixed latency.
// When a tag reaches the end of the pipe, the divider output (or the IEEE-754
// special-case result) goes into a small result FIFO. The divider cannot be
// stalled, so a result that arrives while the FIFO is full is dropped and
// counted.
//
// Build option:
//   FPDIV_SPECIAL_EN  when defined, special operands (NaN, inf, zero,
//                     denormal-as-zero) are classified at issue and their
//                     result overrides div_c. When not defined, div_c is
//                     always pushed and out_flags is constant 0.
//
// Parameters:
//   LATENCY    divider issue-to-result latency in cycles
//   DEPTH      result FIFO entries (power of two, >= 2)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   D          issue strobe (A/B sampled with it)
//   A, B       dividend / divisor
//   div_c      divider result, valid LATENCY edges after D was sampled
//   out_ready  consumer accepts the head entry
//   out_valid  FIFO not empty
//   out_data   head result
//   out_flags  head flags: [1] invalid, [0] divide-by-zero
//   level      FIFO occupancy
//   overrun    sticky: a completed result was dropped
//   drop_cnt   saturating count of dropped results

module fpdiv_result_stage #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   D,
    input  logic [31:0]            A,
    input  logic [31:0]            B,
    input  logic [31:0]            div_c,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [31:0]            out_data,
    output logic [1:0]             out_flags,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overrun,
    output logic [7:0]             drop_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Tag pipe: valid bits (always built)
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] tag_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid_q <= '0;
        end else begin
            tag_valid_q[0] <= D;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
            end
        end
    end

    logic        comp_valid;
    logic [31:0] comp_data;

    assign comp_valid = tag_valid_q[LATENCY-1];

`ifdef FPDIV_SPECIAL_EN
    // ------------------------------------------------------------------
    // Operand classification at issue time
    // ------------------------------------------------------------------
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;
    logic sgn;

    // Denormals have a zero exponent and are treated as zero.
    assign a_zero = (A[30:23] == 8'h00);
    assign a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == '0);
    assign a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != '0);
    assign b_zero = (B[30:23] == 8'h00);
    assign b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == '0);
    assign b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != '0);
    assign sgn    = A[31] ^ B[31];

    logic        cls_special;
    logic [31:0] cls_ovr;
    logic [1:0]  cls_flags;

    // Priority order matters: the invalid cases are removed first, so the
    // later branches can assume neither operand is NaN.
    always_comb begin
        cls_special = 1'b1;
        cls_ovr     = '0;
        cls_flags   = 2'b00;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            cls_ovr   = 32'h7FC0_0000;
            cls_flags = 2'b10;
        end else if (b_zero && !a_inf) begin
            // finite nonzero / 0
            cls_ovr   = {sgn, 31'h7F80_0000};
            cls_flags = 2'b01;
        end else if (a_inf) begin
            // inf / finite (including inf / 0, which is exact)
            cls_ovr = {sgn, 31'h7F80_0000};
        end else if (a_zero || b_inf) begin
            cls_ovr = {sgn, 31'h0000_0000};
        end else begin
            cls_special = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipe: override payload
    // ------------------------------------------------------------------
    logic        tag_special_q [LATENCY];
    logic [31:0] tag_ovr_q     [LATENCY];
    logic [1:0]  tag_flags_q   [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_special_q[i] <= 1'b0;
                tag_ovr_q[i]     <= '0;
                tag_flags_q[i]   <= 2'b00;
            end
        end else begin
            tag_special_q[0] <= cls_special;
            tag_ovr_q[0]     <= cls_ovr;
            tag_flags_q[0]   <= cls_flags;
            for (int i = 1; i < LATENCY; i++) begin
                tag_special_q[i] <= tag_special_q[i-1];
                tag_ovr_q[i]     <= tag_ovr_q[i-1];
                tag_flags_q[i]   <= tag_flags_q[i-1];
            end
        end
    end

    logic [1:0] comp_flags;

    assign comp_data  = tag_special_q[LATENCY-1] ? tag_ovr_q[LATENCY-1] : div_c;
    assign comp_flags = tag_flags_q[LATENCY-1];
`else
    // Operands are only needed by the classifier.
    logic unused_operands;
    assign unused_operands = ^{A, B};

    assign comp_data = div_c;
`endif

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [31:0]     mem_data_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            full, pop, push, drop;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == (PtrW+1)'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A full FIFO can still take the result if the head leaves on this edge.
    assign push      = comp_valid && (!full || pop);
    assign drop      = comp_valid && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= comp_data;
                wr_ptr_q             <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PtrW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PtrW+1)'(1);
            end
        end
    end

    assign out_data = mem_data_q[rd_ptr_q];
    assign level    = count_q;

`ifdef FPDIV_SPECIAL_EN
    logic [1:0] mem_flags_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_flags_q[i] <= 2'b00;
            end
        end else if (push) begin
            mem_flags_q[wr_ptr_q] <= comp_flags;
        end
    end

    assign out_flags = mem_flags_q[rd_ptr_q];
`else
    assign out_flags = 2'b00;
`endif

    // ------------------------------------------------------------------
    // Drop accounting
    // ------------------------------------------------------------------
    logic       overrun_q;
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else if (drop) begin
            overrun_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign overrun  = overrun_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fpdiv_result_stage.sv
// tb_fpdiv_result_stage
//
// Testbench for fpdiv_result_stage. A reference model keeps in-flight ops
// in a queue keyed by completion edge, works out each op's expected result
// from the IEEE special-case rules, and tracks the result FIFO as a queue
// together with drop bookkeeping. Outputs are compared one time unit after
// every rising edge.

module tb_fpdiv_result_stage;

    localparam int unsigned LATENCY = 4;
    localparam int unsigned DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        D = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] div_c = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_flags;
    logic [2:0]  level;
    logic        overrun;
    logic [7:0]  drop_cnt;

    fpdiv_result_stage #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .D         (D),
        .A         (A),
        .B         (B),
        .div_c     (div_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_flags (out_flags),
        .level     (level),
        .overrun   (overrun),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned due;
        logic [31:0] divc;
        logic [33:0] res;   // {flags, data}
    } op_t;

    op_t         inflight[$];
    logic [33:0] fifo_m[$];
    int unsigned drops_m = 0;
    logic        ovr_m   = 1'b0;
    int unsigned edge_n  = 0;

    function automatic bit f_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction
    function automatic bit f_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction
    function automatic bit f_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [33:0] expect_of(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] divc);
`ifdef FPDIV_SPECIAL_EN
        logic s;
        s = a[31] ^ b[31];
        if (f_nan(a) || f_nan(b) || (f_zero(a) && f_zero(b)) || (f_inf(a) && f_inf(b)))
            return {2'b10, 32'h7FC0_0000};
        if (f_zero(b) && !f_inf(a))
            return {2'b01, s, 31'h7F80_0000};
        if (f_inf(a))
            return {2'b00, s, 31'h7F80_0000};
        if (f_zero(a) || f_inf(b))
            return {2'b00, s, 31'h0};
`endif
        return {2'b00, divc};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
            default: if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[30:23] = 8'h80;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        int unsigned n;
        n = fifo_m.size();
        check("out_valid", 32'(out_valid), 32'(n != 0));
        check("level", 32'(level), n);
        if (n != 0) begin
            check("out_data", out_data, fifo_m[0][31:0]);
            check("out_flags", 32'(out_flags), 32'(fifo_m[0][33:32]));
        end
        check("overrun", 32'(overrun), 32'(ovr_m));
        check("drop_cnt", 32'(drop_cnt), drops_m);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_out_flags"}, 32'(out_flags), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    // One clock cycle: drive inputs, advance the model by one edge, compare.
    task automatic tick(input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic rdy);
        op_t         op;
        logic        comp_m, pop_m, full_m;
        logic [33:0] comp_res;
        D         = d;
        A         = a;
        B         = b;
        out_ready = rdy;
        if (inflight.size() > 0 && inflight[0].due == edge_n) div_c = inflight[0].divc;
        else div_c = $urandom;
        if (d) begin
            op.due  = edge_n + LATENCY;
            op.divc = res;
            op.res  = expect_of(a, b, res);
            inflight.push_back(op);
        end
        @(posedge clk);
        comp_m   = inflight.size() > 0 && inflight[0].due == edge_n;
        comp_res = '0;
        if (comp_m) begin
            comp_res = inflight[0].res;
            inflight.delete(0);
        end
        full_m = (fifo_m.size() == DEPTH);
        pop_m  = (fifo_m.size() > 0) && rdy;
        if (pop_m) fifo_m.delete(0);
        if (comp_m) begin
            if (!full_m || pop_m) begin
                fifo_m.push_back(comp_res);
            end else begin
                ovr_m = 1'b1;
                if (drops_m < 255) drops_m++;
            end
        end
        edge_n++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int unsigned n, input logic rdy);
        for (int i = 0; i < n; i++) tick(1'b0, $urandom, $urandom, $urandom, rdy);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst_init");
        rst = 1'b1;

        // Plain op: 2.0 / 1.0
        tick(1'b1, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b1);
        idle(LATENCY, 1'b1);
        check("first_data", out_data, 32'h4000_0000);
        check("first_valid", 32'(out_valid), 32'd1);
        idle(3, 1'b1);

        // Special operands with garbage divider output
        tick(1'b1, 32'h3F80_0000, 32'h0000_0000, $urandom, 1'b1);
        tick(1'b1, 32'h8000_0000, 32'h0000_0000, $urandom, 1'b1);
        idle(LATENCY - 1, 1'b1);
`ifdef FPDIV_SPECIAL_EN
        check("one_div_zero", out_data, 32'h7F80_0000);
        check("one_div_zero_flags", 32'(out_flags), 32'd1);
`endif
        tick(1'b0, $urandom, $urandom, $urandom, 1'b1);
`ifdef FPDIV_SPECIAL_EN
        check("zero_div_zero", out_data, 32'h7FC0_0000);
        check("zero_div_zero_flags", 32'(out_flags), 32'd2);
`endif
        idle(3, 1'b1);

        // Back-to-back: 9 ops, one per cycle
        tick(1'b1, 32'h4110_0000, 32'h3EA8_F5C3, 32'h41DA_2E8B, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b1, rand_operand(), rand_operand(), $urandom, 1'b1);
        idle(LATENCY + 2, 1'b1);
        check("b2b_drained", 32'(level), 32'd0);

        // Backpressure: 6 ops into a 4-entry FIFO
        for (int i = 0; i < 6; i++) tick(1'b1, rand_operand(), rand_operand(), $urandom, 1'b0);
        idle(LATENCY, 1'b0);
        check("bp_level", 32'(level), 32'd4);
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_drop_cnt", 32'(drop_cnt), 32'd2);
        idle(DEPTH + 1, 1'b1);
        check("bp_drained", 32'(level), 32'd0);

        // Full FIFO with pop and completion on the same edge
        for (int i = 0; i < 5; i++) tick(1'b1, rand_operand(), rand_operand(), $urandom, 1'b0);
        idle(3, 1'b0);
        check("full_before", 32'(level), 32'd4);
        idle(1, 1'b1);
        check("full_swap_level", 32'(level), 32'd4);
        check("full_swap_drop_cnt", 32'(drop_cnt), 32'd2);
        idle(DEPTH + 1, 1'b1);

        // Drop counter saturation
        for (int i = 0; i < 270; i++) tick(1'b1, rand_operand(), rand_operand(), $urandom, 1'b0);
        idle(LATENCY, 1'b0);
        check("drop_sat", 32'(drop_cnt), 32'd255);
        idle(DEPTH + 1, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom_range(0, 1)), rand_operand(), rand_operand(), $urandom,
                 1'($urandom_range(0, 3) != 0));
        end
        idle(2, 1'b0);

        // Reset in the middle of operation
        for (int i = 0; i < 3; i++) tick(1'b1, rand_operand(), rand_operand(), $urandom, 1'b0);
        idle(2, 1'b0);
        rst = 1'b0;
        #1;
        check_reset_values("rst_mid");
        inflight.delete();
        fifo_m.delete();
        drops_m = 0;
        ovr_m   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, $urandom, $urandom, $urandom, 1'b1);
            check("post_rst_valid", 32'(out_valid), 32'd0);
        end

        // Normal operation resumes after reset
        tick(1'b1, 32'h4110_0000, 32'h3EA8_F5C3, 32'h41DA_2E8B, 1'b0);
        idle(LATENCY, 1'b0);
        check("post_rst_data", out_data, 32'h41DA_2E8B);
        idle(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fpdiv_result_stage.md
# fpdiv_result_stage

Downstream completion stage for the pipelined Newton-Raphson FP32 divider. It tracks each issued operation through the divider's fixed latency and replaces the divider output with the IEEE-754 result for special operands. Completed results go into a small FIFO behind a valid/ready interface, so a back-pressuring consumer never stalls the divider, which cannot be stalled.

## Interface
- LATENCY, 4: divider issue-to-result latency in cycles; `div_c` is valid exactly LATENCY edges after `D` is sampled high.
- DEPTH, 4: result FIFO entries, power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- D  in  1  issue strobe, tied to the divider's `D`.
- A  in  32  dividend, tied to the divider's `A`, sampled with `D`.
- B  in  32  divisor, tied to the divider's `B`, sampled with `D`.
- div_c  in  32  divider result (`C`).
- out_ready  in  1  consumer accepts the head entry.
- out_valid  out  1  FIFO not empty.
- out_data  out  32  head result.
- out_flags  out  2  head flags: bit1 = invalid, bit0 = divide-by-zero.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- overrun  out  1  sticky: a completed result was dropped.
- drop_cnt  out  8  saturating count of dropped results.

## Operation
- Tag pipe: a LATENCY-deep shift register. Each stage holds a valid bit, a special bit, a 32-bit override and 2 flags. Stage 0 loads `D` and the classification of A/B on every edge.
- Classification uses FP32 fields. Denormals count as zero. s = sign(A) XOR sign(B).
  - Either operand NaN, 0/0, or inf/inf: override 0x7FC00000, invalid = 1.
  - Finite nonzero divided by 0: override {s, 0x7F800000[30:0]}, divide-by-zero = 1.
  - inf divided by finite: {s, 0x7F800000[30:0]}.
  - 0 divided by nonzero, or finite divided by inf: {s, 31'b0}.
  - Otherwise special = 0, flags = 0.
- Completion happens when the last tag stage is valid. Data = override if special, else `div_c`. It is pushed to the FIFO with its flags.
- Push is accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge. Otherwise the result is dropped: `overrun` is set and `drop_cnt` increments, saturating at 255.
- Pop occurs on the edge where out_valid and out_ready are both 1. out_data and out_flags come straight from the head register with no combinational path from out_ready.
- Push and pop on the same edge leave level unchanged. Pointers wrap modulo DEPTH.
- An issue while completions are pending is normal. One op enters and one completes per cycle.

## Timing
- An op with `D` sampled at edge N completes at edge N+LATENCY. out_valid is 1 after edge N+LATENCY if the FIFO was empty.
- Throughput is one result per cycle when out_ready is held at 1.
- Reset values: out_valid = 0, out_data = 0, out_flags = 0, level = 0, overrun = 0, drop_cnt = 0, and all tag valid bits = 0.
- Reset mid-operation discards every in-flight tag and every FIFO entry. Ops issued before reset never produce output.
- Nothing completes in the first LATENCY edges after reset release. A stale `div_c` is ignored because the tags are invalid.
- `overrun` clears only on reset.

## Configuration
- FPDIV_SPECIAL_EN
  - Defined: classification and override are active as described above.
  - Not defined: the classifier and override fields are not built, `div_c` is always pushed, and out_flags is constant 0. The tag pipe carries only valid bits.

## Test plan
- Ops: A = 0x40000000, B = 0x3F800000, D = 1 for 1 cycle, div_c = 0x40000000 at edge +4, out_ready = 1 -> out_valid pulses 1 cycle after edge +4 with out_data 0x40000000 and flags 00.
- Op: A = 0x3F800000, B = 0x00000000 with div_c driven to garbage -> out_data 0x7F800000, flags 01. Op: A = 0x80000000, B = 0x00000000 -> 0x7FC00000, flags 10. Without FPDIV_SPECIAL_EN -> garbage value passes through, flags 00.
- Back-to-back: 9 ops, one per cycle (A/B from the divider regression set, e.g. 0x41100000 / 0x3EA8F5C3 -> 0x41DA2E8B), out_ready = 1 -> 9 results in issue order on consecutive cycles.
- Backpressure: out_ready = 0, 6 ops issued -> level reaches 4, overrun = 1, drop_cnt = 2. Then out_ready = 1 -> the first 4 results drain in order and level returns to 0.
- Full FIFO with out_ready = 1 and a simultaneous completion -> no drop, level stays at 4.
- rst asserted 2 cycles after issuing 3 ops -> all outputs return to reset values immediately. After release, with no new issue, out_valid stays 0 for at least 10 cycles.
